// File: rtl/mult.sv
// -----------------------------------------------------------------------------
// mult -- two-stage pipelined multiplier for the digit-recognition MAC datapath.
//
// Computes the full-precision product s = a * b (2*WIDTH bits, no truncation)
// of two's-complement operands using radix-4 Booth recoding of b.
//   Stage 1: Booth partial-product generation and carry-save reduction of all
//            partial products (plus the negation correction bits) into a
//            sum/carry pair.
//   Stage 2: carry-propagate add into the output register.
// A valid bit travels with the data. When in_valid is low the data registers
// hold their value, so s is unchanged while out_valid is low.
//
// Optional feature (compile-time macro MULT_TC_SELECT_EN):
//   Adds input tc, sampled with a/b. tc=1 gives the signed product, tc=0
//   treats both operands as unsigned (zero-extended, one extra Booth digit).
//   Without the macro the port is absent and the block is always signed.
//
// Parameters:
//   WIDTH      operand width in bits, even and >= 4
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every pipeline register
//   in_valid   a/b (and tc) are sampled this cycle
//   tc         (MULT_TC_SELECT_EN only) 1 = signed, 0 = unsigned operands
//   a          multiplicand
//   b          multiplier (Booth-recoded)
//   s          registered product, 2*WIDTH bits
//   out_valid  s holds the product of the pair presented two cycles earlier
// -----------------------------------------------------------------------------
`default_nettype none

module mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
`ifdef MULT_TC_SELECT_EN
  input  logic               tc,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] s,
  output logic               out_valid
);

  localparam int PW = 2 * WIDTH;   // product width

  // Booth operand width. Unsigned support needs two extra (zero) bits so the
  // top Booth digit never sees a spurious sign; this adds one digit.
`ifdef MULT_TC_SELECT_EN
  localparam int BW = WIDTH + 2;
`else
  localparam int BW = WIDTH;
`endif
  localparam int ND = BW / 2;      // number of Booth digits

  // ---------------------------------------------------------------------------
  // Operand extension
  // ---------------------------------------------------------------------------
  logic [BW-1:0] a_ext;
  logic [BW-1:0] b_ext;

`ifdef MULT_TC_SELECT_EN
  assign a_ext = {{2{tc & a[WIDTH-1]}}, a};
  assign b_ext = {{2{tc & b[WIDTH-1]}}, b};
`else
  assign a_ext = a;
  assign b_ext = b;
`endif

  logic [PW-1:0] a_wide;   // multiplicand sign-extended to product width
  logic [BW:0]   b_pad;    // b with the implicit zero below bit 0

  assign a_wide = {{(PW-BW){a_ext[BW-1]}}, a_ext};
  assign b_pad  = {b_ext, 1'b0};

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: Booth partial products and carry-save reduction
  // ---------------------------------------------------------------------------
  logic [2:0]    trip;
  logic [PW-1:0] mag;
  logic          neg;
  logic [PW-1:0] pp;
  logic [PW-1:0] corr;      // +1 injections that complete each negation
  logic [PW-1:0] sum_v;
  logic [PW-1:0] carry_v;
  logic [PW-1:0] t_sum;
  logic [PW-1:0] t_car;

  // NOTE: every variable written here gets a default before any branch or
  // loop, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    trip    = '0;
    mag     = '0;
    neg     = 1'b0;
    pp      = '0;
    corr    = '0;
    sum_v   = '0;
    carry_v = '0;
    t_sum   = '0;
    t_car   = '0;

    for (int i = 0; i < ND; i++) begin
      trip = 3'(b_pad >> (2 * i));
      case (trip)
        3'b000, 3'b111:                 mag = '0;           //  0
        3'b001, 3'b010, 3'b101, 3'b110: mag = a_wide;       // +/-1
        default:                        mag = a_wide << 1;  // +/-2
      endcase
      // 111 encodes -0: treat as zero rather than ~0 + 1.
      neg  = trip[2] & ~(trip[1] & trip[0]);
      // Complement before shifting so the vacated low bits stay zero; the
      // matching +1 goes into corr at the digit's weight.
      pp   = (neg ? ~mag : mag) << (2 * i);
      corr = corr | ({{(PW-1){1'b0}}, neg} << (2 * i));

      t_sum   = sum_v ^ carry_v ^ pp;
      t_car   = ((sum_v & carry_v) | (sum_v & pp) | (carry_v & pp)) << 1;
      sum_v   = t_sum;
      carry_v = t_car;
    end

    t_sum   = sum_v ^ carry_v ^ corr;
    t_car   = ((sum_v & carry_v) | (sum_v & corr) | (carry_v & corr)) << 1;
    sum_v   = t_sum;
    carry_v = t_car;
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic [PW-1:0] s1_sum;
  logic [PW-1:0] s1_carry;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order. The data
  // registers are reset too, because s must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= '0;
    end else begin
      s1_valid <= in_valid;
      // Load only on valid: keeps the data path quiet and keeps undefined
      // operands out of the pipeline.
      if (in_valid) begin
        s1_sum   <= sum_v;
        s1_carry <= carry_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s <= s1_sum + s1_carry;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult.sv
// -----------------------------------------------------------------------------
// tb_mult -- directed self-checking bench for mult (WIDTH = 8).
// Inputs are driven 1 time unit after the rising edge; outputs are read at
// the same point, well away from the next edge. A pair presented before edge
// E appears on s with out_valid after edge E+1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mult;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           tc;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] s;
  logic           out_valid;

  int vectors    = 0;
  int miscompares = 0;

  mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
`ifdef MULT_TC_SELECT_EN
    .tc        (tc),
`endif
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
  endtask

  // Present one pair, idle afterwards, and compare after the second edge.
  // Also confirms out_valid is still low after the first edge.
  task automatic single(input string name, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [2*W-1:0] exp_s);
    issue(va, vb);
    step();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_latency: out_valid=%b after one edge, want 0", name, out_valid);
    end
    step();
    vectors++;
    if (s !== exp_s || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: s=%h out_valid=%b, want s=%h out_valid=1",
               name, s, out_valid, exp_s);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tc       = 1'b1;
    a        = 8'd7;
    b        = 8'd1;
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      step();
      vectors++;
      if (s !== 16'h0000 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: s=%h out_valid=%b, want s=0000 out_valid=0",
                 i, s, out_valid);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    single("reset_release_7x1", 8'd7, 8'd1, 16'h0007);
  endtask

  task automatic test_signed_mixed();
    single("neg5_x_3", 8'hFB, 8'h03, 16'hFFF1);
    single("3_x_neg5", 8'h03, 8'hFB, 16'hFFF1);
  endtask

  task automatic test_extremes();
    single("min_x_min", 8'h80, 8'h80, 16'h4000);
    single("max_x_min", 8'h7F, 8'h80, 16'hC080);
    single("max_x_max", 8'h7F, 8'h7F, 16'h3F01);
    single("0_x_neg1",  8'h00, 8'hFF, 16'h0000);
  endtask

  // Four consecutive pairs, a bubble with undefined operands, one more pair.
  task automatic test_back_to_back();
    logic [W-1:0]   va [7] = '{8'd7, 8'hFB, 8'hFF, 8'd2, 8'h00, 8'd3, 8'h00};
    logic [W-1:0]   vb [7] = '{8'd1, 8'd3, 8'hFF, 8'hC0, 8'h00, 8'd3, 8'h00};
    logic           vv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2*W-1:0] es [7] = '{16'h0007, 16'hFFF1, 16'h0001, 16'hFF80,
                               16'hFF80, 16'h0009, 16'h0009};
    for (int c = 0; c < 8; c++) begin
      if (c < 7 && vv[c]) begin
        issue(va[c], vb[c]);
      end else begin
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
      end
      step();
      if (c >= 1) begin
        vectors++;
        if (s !== es[c-1] || out_valid !== vv[c-1]) begin
          miscompares++;
          $display("FAIL stream[%0d]: s=%h out_valid=%b, want s=%h out_valid=%b",
                   c - 1, s, out_valid, es[c-1], vv[c-1]);
        end
      end
    end
  endtask

  // Random stream against a reference product; invalid slots carry random
  // operands that must not disturb s.
  task automatic test_random();
    localparam int N = 200;
    logic [W-1:0]   ra [N];
    logic [W-1:0]   rb [N];
    logic           rv [N];
    logic           rt [N];
    logic [2*W-1:0] held;
    logic [2*W-1:0] want;
    for (int k = 0; k < N; k++) begin
      ra[k] = W'($urandom);
      rb[k] = W'($urandom);
      rv[k] = (k == 0) || ($urandom_range(3) != 0);
`ifdef MULT_TC_SELECT_EN
      rt[k] = 1'($urandom);
`else
      rt[k] = 1'b1;
`endif
    end
    held = '0;
    for (int c = 0; c <= N; c++) begin
      if (c < N) begin
        a        = ra[c];
        b        = rb[c];
        in_valid = rv[c];
        tc       = rt[c];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        if (rv[c-1]) begin
          if (rt[c-1]) held = $signed(ra[c-1]) * $signed(rb[c-1]);
          else         held = ra[c-1] * rb[c-1];
        end
        want = held;
        vectors++;
        if (s !== want || out_valid !== rv[c-1]) begin
          miscompares++;
          $display("FAIL random[%0d] a=%h b=%h tc=%b: s=%h out_valid=%b, want s=%h out_valid=%b",
                   c - 1, ra[c-1], rb[c-1], rt[c-1], s, out_valid, want, rv[c-1]);
        end
      end
    end
    tc = 1'b1;
  endtask

`ifdef MULT_TC_SELECT_EN
  task automatic test_tc_select();
    tc = 1'b0;
    single("unsigned_FBx3",  8'hFB, 8'h03, 16'h02F1);
    single("unsigned_FFxFF", 8'hFF, 8'hFF, 16'hFE01);
    single("unsigned_80x80", 8'h80, 8'h80, 16'h4000);
    tc = 1'b1;
    single("signed_FBx3",    8'hFB, 8'h03, 16'hFFF1);
    single("signed_FFxFF",   8'hFF, 8'hFF, 16'h0001);
  endtask
`endif

  task automatic test_reset_midflight();
    issue(8'd5, 8'd5);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;   // pair is in stage 1 now
    #1;
    vectors++;
    if (s !== 16'h0000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_async: s=%h out_valid=%b, want s=0000 out_valid=0",
               s, out_valid);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (s !== 16'h0000 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midflight_after[%0d]: s=%h out_valid=%b, want s=0000 out_valid=0",
                 i, s, out_valid);
      end
    end
    single("post_reset_6x7", 8'd6, 8'd7, 16'h002A);
  endtask

  initial begin
    test_reset();
    test_signed_mixed();
    test_extremes();
    test_back_to_back();
    test_random();
`ifdef MULT_TC_SELECT_EN
    test_tc_select();
`endif
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
